// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter granting one of NREQ requesters access to a shared I2C byte engine.
// It launches one byte per grant and returns a done/err pulse to the owner.
module i2c_req_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*N-1:0] i_req_data,
  output logic [NREQ-1:0]   o_gnt,
  output logic [NREQ-1:0]   o_done,
  output logic [NREQ-1:0]   o_err,
  output logic              o_busy,
  output logic              o_eng_start,
  output logic [N-1:0]      o_eng_data,
  input  logic              i_eng_busy,
  input  logic              i_eng_ack_ok
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StLaunch,
    StWaitBusy,
    StWaitDone,
    StRelease
  } state_e;

  state_e          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_win;
  logic [TW-1:0]   r_tcnt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [NREQ-1:0] r_err;
  logic            r_busy;
  logic            r_eng_start;
  logic [N-1:0]    r_eng_data;

  logic            w_found;
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_win;
  logic [N-1:0]    w_win_data;
  logic [TW-1:0]   w_tcnt_nxt;
  logic            w_tmo;

  // Search starts just above the last winner and wraps, so the last owner has lowest priority.
  always_comb begin
    w_found    = 1'b0;
    w_idx      = '0;
    w_win      = '0;
    w_win_data = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      w_idx = PW'((int'(r_ptr) + k) % int'(NREQ));
      if (!w_found && i_req[w_idx]) begin
        w_found    = 1'b1;
        w_win      = w_idx;
        w_win_data = i_req_data[int'(w_idx) * int'(N) +: N];
      end
    end
  end

  assign w_tcnt_nxt = r_tcnt + TW'(1);
  assign w_tmo      = (w_tcnt_nxt == TW'(TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_ptr       <= PW'(NREQ - 1);
      r_win       <= '0;
      r_tcnt      <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_busy      <= 1'b0;
      r_eng_start <= 1'b0;
      r_eng_data  <= '0;
    end else begin
      r_done      <= '0;
      r_err       <= '0;
      r_eng_start <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_state    <= StGrant;
            r_win      <= w_win;
            r_gnt      <= {{(NREQ - 1){1'b0}}, 1'b1} << w_win;
            r_eng_data <= w_win_data;
            r_busy     <= 1'b1;
          end
        end
        StGrant: begin
          r_state     <= StLaunch;
          r_eng_start <= 1'b1;
        end
        StLaunch: begin
          // Engine busy seen during launch is deliberately ignored.
          r_state <= StWaitBusy;
          r_tcnt  <= '0;
        end
        StWaitBusy: begin
          r_tcnt <= w_tcnt_nxt;
          if (w_tmo) begin
            r_state <= StRelease;
            r_err   <= r_gnt;
          end else if (i_eng_busy) begin
            r_state <= StWaitDone;
          end
        end
        StWaitDone: begin
          r_tcnt <= w_tcnt_nxt;
          if (w_tmo) begin
            r_state <= StRelease;
            r_err   <= r_gnt;
          end else if (!i_eng_busy) begin
            r_state <= StRelease;
            if (i_eng_ack_ok) begin
              r_done <= r_gnt;
            end else begin
              r_err <= r_gnt;
            end
          end
        end
        StRelease: begin
          r_state <= StIdle;
          r_ptr   <= r_win;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_busy      = r_busy;
  assign o_eng_start = r_eng_start;
  assign o_eng_data  = r_eng_data;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: transaction-level model compared every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_i2c_req_arbiter;

  localparam int NREQ    = 4;
  localparam int N       = 8;
  localparam int TIMEOUT = 255;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   err;
  logic              busy;
  logic              eng_start;
  logic [N-1:0]      eng_data;
  logic              eng_busy;
  logic              eng_ack_ok;

  i2c_req_arbiter #(
    .NREQ    (NREQ),
    .N       (N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req        (req),
    .i_req_data   (req_data),
    .o_gnt        (gnt),
    .o_done       (done),
    .o_err        (err),
    .o_busy       (busy),
    .o_eng_start  (eng_start),
    .o_eng_data   (eng_data),
    .i_eng_busy   (eng_busy),
    .i_eng_ack_ok (eng_ack_ok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_err;
  int n_checks;
  int cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Byte engine: busy for eng_len cycles after seeing a launch, unless in never-busy mode.
  int eng_len;
  int eng_mode;
  int eng_cnt;
  initial begin
    logic st;
    logic rs;
    eng_busy = 1'b0;
    eng_cnt  = 0;
    forever begin
      @(negedge clk);
      st = eng_start;
      rs = reset;
      @(posedge clk);
      #1;
      if (rs) begin
        eng_busy = 1'b0;
        eng_cnt  = 0;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) eng_busy = 1'b0;
      end else if (st === 1'b1 && eng_mode == 0) begin
        eng_busy = 1'b1;
        eng_cnt  = eng_len;
      end
    end
  end

  // Transaction model: age counts cycles since the grant; waits counts elapsed wait cycles.
  bit              m_valid;
  bit              m_tx;
  bit              m_rel;
  bit              m_seen;
  int              m_ptr;
  int              m_owner;
  int              m_age;
  int              m_waits;
  logic [NREQ-1:0] m_gnt;
  logic [NREQ-1:0] m_done;
  logic [NREQ-1:0] m_err;
  logic            m_start;
  logic [N-1:0]    m_data;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_tx    = 1'b0;
      m_rel   = 1'b0;
      m_ptr   = NREQ - 1;
      m_gnt   = '0;
      m_done  = '0;
      m_err   = '0;
      m_start = 1'b0;
      m_data  = '0;
    end else if (m_valid) begin
      m_done  = '0;
      m_err   = '0;
      m_start = 1'b0;
      if (m_rel) begin
        m_rel = 1'b0;
        m_tx  = 1'b0;
        m_ptr = m_owner;
        m_gnt = '0;
      end else if (!m_tx) begin
        if (req != '0) begin
          for (int k = 1; k <= NREQ; k++) begin
            if (!m_tx && req[(m_ptr + k) % NREQ]) begin
              m_owner = (m_ptr + k) % NREQ;
              m_tx    = 1'b1;
            end
          end
          m_age          = 1;
          m_gnt          = '0;
          m_gnt[m_owner] = 1'b1;
          m_data         = req_data[m_owner * N +: N];
        end
      end else begin
        m_age++;
        if (m_age == 2) begin
          m_start = 1'b1;
        end else if (m_age == 3) begin
          m_waits = 0;
          m_seen  = 1'b0;
        end else begin
          m_waits++;
          if (m_waits == TIMEOUT) begin
            m_err = m_gnt;
            m_rel = 1'b1;
          end else if (!m_seen) begin
            if (eng_busy) m_seen = 1'b1;
          end else if (!eng_busy) begin
            if (eng_ack_ok) m_done = m_gnt;
            else m_err = m_gnt;
            m_rel = 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle compare plus event log for the directed checks.
  logic [NREQ-1:0] prev_gnt;
  int              glog[$];
  int              gap_viol;
  int              g_cyc;
  int              s_cyc;
  int              e_cyc;
  logic [N-1:0]    g_data;
  int              done_cnt[NREQ];
  int              err_cnt[NREQ];
  int              done_tot;
  int              err_tot;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("busy", 32'(busy), 32'(m_tx));
      chk("eng_start", 32'(eng_start), 32'(m_start));
      chk("eng_data", 32'(eng_data), 32'(m_data));
      if (gnt != '0 && gnt != prev_gnt) begin
        if (prev_gnt != '0) gap_viol++;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) glog.push_back(i);
        g_cyc  = cyc;
        g_data = eng_data;
      end
      if (eng_start) s_cyc = cyc;
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) begin
          done_cnt[i]++;
          done_tot++;
        end
        if (err[i]) begin
          err_cnt[i]++;
          err_tot++;
          e_cyc = cyc;
        end
      end
      prev_gnt = gnt;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    for (int i = 0; i < NREQ; i++) begin
      done_cnt[i] = 0;
      err_cnt[i]  = 0;
    end
    done_tot = 0;
    err_tot  = 0;
  endtask

  task automatic wait_gnt(input string name, input int bound);
    int k = 0;
    while (gnt == '0 && k < bound) begin
      step(1);
      k++;
    end
    if (gnt == '0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: no grant within %0d cycles", name, bound);
    end
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k = 0;
    step(1);
    while (busy && k < bound) begin
      step(1);
      k++;
    end
    if (busy) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: still busy after %0d cycles", name, bound);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    int snap;
    int exp_rr[5];
    exp_rr     = '{0, 1, 2, 3, 0};
    n_err      = 0;
    n_checks   = 0;
    cyc        = 0;
    gap_viol   = 0;
    prev_gnt   = '0;
    reset      = 1'b1;
    req        = '0;
    req_data   = '0;
    eng_ack_ok = 1'b1;
    eng_len    = 20;
    eng_mode   = 0;
    clr();
    step(3);
    reset = 1'b0;
    step(1);
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_eng_data", 32'(eng_data), 32'h0);

    // Single request with ACK.
    clr();
    req_data = 32'h0000_00A5;
    req      = 4'b0001;
    t0       = cyc;
    wait_gnt("single_gnt", 10);
    req = '0;
    wait_idle("single_idle", 100);
    chk("single_gnt_latency", 32'(g_cyc - t0), 32'd1);
    chk("single_start_latency", 32'(s_cyc - t0), 32'd2);
    chk("single_eng_data", 32'(g_data), 32'hA5);
    chk("single_done0", 32'(done_cnt[0]), 32'd1);
    chk("single_err", 32'(err_tot), 32'd0);
    chk("single_gnt_after", 32'(gnt), 32'h0);

    // Round-robin with all four requesting from reset.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    glog.delete();
    gap_viol = 0;
    eng_len  = 3;
    req_data = 32'h4433_2211;
    req      = 4'b1111;
    t0       = 0;
    while (glog.size() < 5 && t0 < 400) begin
      step(1);
      t0++;
    end
    req = '0;
    wait_idle("rr_idle", 100);
    chk("rr_count", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("rr_order", 32'(glog[i]), 32'(exp_rr[i]));
    chk("rr_idle_gap", 32'(gap_viol), 32'd0);

    // NACK.
    clr();
    eng_ack_ok = 1'b0;
    eng_len    = 5;
    req        = 4'b0001;
    wait_gnt("nack_gnt", 10);
    req = '0;
    wait_idle("nack_idle", 100);
    chk("nack_err0", 32'(err_cnt[0]), 32'd1);
    chk("nack_done", 32'(done_tot), 32'd0);
    eng_ack_ok = 1'b1;

    // Timeout: release follows the 255th wait cycle, i.e. 256 cycles after the launch pulse.
    clr();
    eng_mode = 1;
    req      = 4'b0001;
    wait_gnt("tmo_gnt", 10);
    req = '0;
    wait_idle("tmo_idle", 400);
    chk("tmo_err_delay", 32'(e_cyc - s_cyc), 32'd256);
    chk("tmo_err0", 32'(err_cnt[0]), 32'd1);
    chk("tmo_done", 32'(done_tot), 32'd0);
    eng_mode = 0;

    // Withdrawal by requester 2 while requester 0 appears mid-transaction.
    clr();
    eng_len = 6;
    req     = 4'b0100;
    wait_gnt("wd_gnt", 10);
    chk("wd_gnt2", 32'(gnt), 32'h4);
    step(1);
    req = 4'b0001;
    wait_idle("wd_idle", 100);
    chk("wd_done2", 32'(done_cnt[2]), 32'd1);
    chk("wd_done0", 32'(done_cnt[0]), 32'd0);
    chk("wd_err", 32'(err_tot), 32'd0);
    wait_gnt("wd_next_gnt", 10);
    chk("wd_next_gnt0", 32'(gnt), 32'h1);
    req = '0;
    wait_idle("wd_next_idle", 100);

    // Reset in WAIT_DONE: pre-reset winner is 2 (ptr=0), post-reset winner is 0.
    clr();
    eng_len = 20;
    req     = 4'b0101;
    wait_gnt("rst_gnt", 10);
    chk("rst_pre_gnt2", 32'(gnt), 32'h4);
    step(6);
    snap  = done_tot + err_tot;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst_gnt_zero", 32'(gnt), 32'h0);
    chk("rst_busy_zero", 32'(busy), 32'h0);
    chk("rst_start_zero", 32'(eng_start), 32'h0);
    chk("rst_pulse_zero", 32'({done, err}), 32'h0);
    chk("rst_data_zero", 32'(eng_data), 32'h0);
    wait_gnt("rst_post_gnt", 10);
    chk("rst_post_gnt0", 32'(gnt), 32'h1);
    chk("rst_no_pulse", 32'(done_tot + err_tot), 32'(snap));
    req = '0;
    wait_idle("rst_post_idle", 100);
    chk("rst_post_done0", 32'(done_cnt[0]), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
